// File: rtl/writeback_commit_unit_l3_pkg.sv
// Shared types for the writeback/commit unit.
//   xw_msg_t    : message from an execute pipe into writeback
//   rob_entry_t : one reorder-buffer slot
//   rob_depth() : ROB depth for a given sequence-number width
// The struct field widths come from SEQ_NUM_BITS / PHYS_ADDR_BITS below. The
// module parameters default to these values and must be kept equal to them.
package writeback_commit_unit_l3_pkg;

    localparam int SEQ_NUM_BITS   = 3;
    localparam int PHYS_ADDR_BITS = 6;

    function automatic int rob_depth(int seq_bits);
        return 1 << seq_bits;
    endfunction

    localparam int ROB_DEPTH = rob_depth(SEQ_NUM_BITS);

    typedef struct packed {
        logic [31:0]               pc;
        logic [SEQ_NUM_BITS-1:0]   seq_num;
        logic [4:0]                waddr;
        logic [31:0]               wdata;
        logic                      wen;
        logic [PHYS_ADDR_BITS-1:0] preg;
        logic [PHYS_ADDR_BITS-1:0] ppreg;
    } xw_msg_t;

    typedef struct packed {
        logic                      valid;
        logic [31:0]               pc;
        logic [4:0]                waddr;
        logic [31:0]               wdata;
        logic                      wen;
        logic [PHYS_ADDR_BITS-1:0] ppreg;
    } rob_entry_t;

endpackage

// File: rtl/writeback_commit_unit_l3_wcu_rob.sv
// wcu_rob: circular reorder buffer.
//   clk, rst        : clock, async active-high reset
//   wr_en/wr_idx    : write port, slot selected by sequence number
//   wr_entry        : entry written (valid bit taken from the entry)
//   commit_*        : head entry, presented whenever the head slot is valid;
//                     it is retired (cleared, head advanced) on the same edge.
module wcu_rob
    import writeback_commit_unit_l3_pkg::*;
#(
    parameter int p_seq_num_bits   = SEQ_NUM_BITS,
    parameter int p_phys_addr_bits = PHYS_ADDR_BITS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [p_seq_num_bits-1:0]   wr_idx,
    input  rob_entry_t                  wr_entry,
    output logic                        commit_val,
    output logic [31:0]                 commit_pc,
    output logic [p_seq_num_bits-1:0]   commit_seq_num,
    output logic [4:0]                  commit_waddr,
    output logic [31:0]                 commit_wdata,
    output logic                        commit_wen,
    output logic [p_phys_addr_bits-1:0] commit_ppreg
);

    localparam int DEPTH = rob_depth(p_seq_num_bits);

    rob_entry_t                rob_q [DEPTH];
    logic [p_seq_num_bits-1:0] head_q;
    rob_entry_t                head_e;

    assign head_e = rob_q[head_q];

    // Head pointer wraps naturally because it is exactly p_seq_num_bits wide.
    // A write never targets the head slot while it retires, so the clear and
    // the write below never collide on the same slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            for (int i = 0; i < DEPTH; i++) rob_q[i] <= '0;
        end else begin
            if (head_e.valid) begin
                rob_q[head_q].valid <= 1'b0;
                head_q              <= head_q + 1'b1;
            end
            if (wr_en) rob_q[wr_idx] <= wr_entry;
        end
    end

    assign commit_val     = head_e.valid;
    assign commit_pc      = head_e.pc;
    assign commit_seq_num = head_q;
    assign commit_waddr   = head_e.waddr;
    assign commit_wdata   = head_e.wdata;
    assign commit_wen     = head_e.wen;
    assign commit_ppreg   = head_e.ppreg;

endmodule

// File: rtl/writeback_commit_unit_l3.sv
// writeback_commit_unit_l3: reordering writeback/commit stage.
//   clk, rst     : clock, async active-high reset
//   ex_*         : per-pipe execute results (packed arrays indexed by pipe),
//                  ex_rdy is the fixed-priority grant (lowest pipe wins)
//   complete_*   : registered completion broadcast, one cycle after accept
//   commit_*     : in-order retirement from the ROB head
// Optional: define WRITEBACK_COMMIT_UNIT_TRACE_EN to get a trace() function.
module writeback_commit_unit_l3
    import writeback_commit_unit_l3_pkg::*;
#(
    parameter int p_num_pipes      = 1,
    parameter int p_seq_num_bits   = SEQ_NUM_BITS,
    parameter int p_phys_addr_bits = PHYS_ADDR_BITS
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [p_num_pipes-1:0]                      ex_val,
    output logic [p_num_pipes-1:0]                      ex_rdy,
    input  logic [p_num_pipes-1:0][31:0]                ex_pc,
    input  logic [p_num_pipes-1:0][p_seq_num_bits-1:0]  ex_seq_num,
    input  logic [p_num_pipes-1:0][4:0]                 ex_waddr,
    input  logic [p_num_pipes-1:0][31:0]                ex_wdata,
    input  logic [p_num_pipes-1:0]                      ex_wen,
    input  logic [p_num_pipes-1:0][p_phys_addr_bits-1:0] ex_preg,
    input  logic [p_num_pipes-1:0][p_phys_addr_bits-1:0] ex_ppreg,
    output logic                                        complete_val,
    output logic [p_seq_num_bits-1:0]                   complete_seq_num,
    output logic [4:0]                                  complete_waddr,
    output logic [31:0]                                 complete_wdata,
    output logic                                        complete_wen,
    output logic [p_phys_addr_bits-1:0]                 complete_preg,
    output logic                                        commit_val,
    output logic [31:0]                                 commit_pc,
    output logic [p_seq_num_bits-1:0]                   commit_seq_num,
    output logic [4:0]                                  commit_waddr,
    output logic [31:0]                                 commit_wdata,
    output logic                                        commit_wen,
    output logic [p_phys_addr_bits-1:0]                 commit_ppreg
);

    logic       accept;
    xw_msg_t    sel_msg;
    rob_entry_t wr_entry;

    // First valid pipe wins. With nothing valid, pipe 0 still shows ready so
    // an idle upstream sees the unit as able to take a message.
    always_comb begin
        ex_rdy  = '0;
        accept  = 1'b0;
        sel_msg = '0;
        for (int i = 0; i < p_num_pipes; i++) begin
            if (ex_val[i] && !accept) begin
                ex_rdy[i]       = 1'b1;
                accept          = 1'b1;
                sel_msg.pc      = ex_pc[i];
                sel_msg.seq_num = ex_seq_num[i];
                sel_msg.waddr   = ex_waddr[i];
                sel_msg.wdata   = ex_wdata[i];
                sel_msg.wen     = ex_wen[i];
                sel_msg.preg    = ex_preg[i];
                sel_msg.ppreg   = ex_ppreg[i];
            end
        end
        if (!accept) ex_rdy[0] = 1'b1;
    end

    // Completion register: data holds its last value between valid pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            complete_val     <= 1'b0;
            complete_seq_num <= '0;
            complete_waddr   <= '0;
            complete_wdata   <= '0;
            complete_wen     <= 1'b0;
            complete_preg    <= '0;
        end else begin
            complete_val <= accept;
            if (accept) begin
                complete_seq_num <= sel_msg.seq_num;
                complete_waddr   <= sel_msg.waddr;
                complete_wdata   <= sel_msg.wdata;
                complete_wen     <= sel_msg.wen;
                complete_preg    <= sel_msg.preg;
            end
        end
    end

    assign wr_entry = '{valid: 1'b1, pc: sel_msg.pc, waddr: sel_msg.waddr,
                        wdata: sel_msg.wdata, wen: sel_msg.wen, ppreg: sel_msg.ppreg};

    wcu_rob #(
        .p_seq_num_bits   (p_seq_num_bits),
        .p_phys_addr_bits (p_phys_addr_bits)
    ) u_rob (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (accept),
        .wr_idx         (sel_msg.seq_num),
        .wr_entry       (wr_entry),
        .commit_val     (commit_val),
        .commit_pc      (commit_pc),
        .commit_seq_num (commit_seq_num),
        .commit_waddr   (commit_waddr),
        .commit_wdata   (commit_wdata),
        .commit_wen     (commit_wen),
        .commit_ppreg   (commit_ppreg)
    );

`ifdef WRITEBACK_COMMIT_UNIT_TRACE_EN
    // "h<head> W<seq> C<seq>", blank-padded to a fixed width when not valid.
    function string trace(int level);
        string s;
        s = $sformatf("h%3d ", u_rob.head_q);
        s = {s, complete_val ? $sformatf("W%3d ", complete_seq_num) : "     "};
        s = {s, commit_val   ? $sformatf("C%3d", commit_seq_num)    : "    "};
        if (level > 1 && commit_val) s = {s, $sformatf(" pc=%08h", commit_pc)};
        return s;
    endfunction
`endif

endmodule

// File: tb/tb_writeback_commit_unit_l3.sv
module tb_writeback_commit_unit_l3;
    localparam int NP = 2, SB = 3, PB = 6, DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NP-1:0]         ex_val = '0, ex_rdy;
    logic [NP-1:0][31:0]   ex_pc = '0, ex_wdata = '0;
    logic [NP-1:0][SB-1:0] ex_seq_num = '0;
    logic [NP-1:0][4:0]    ex_waddr = '0;
    logic [NP-1:0]         ex_wen = '0;
    logic [NP-1:0][PB-1:0] ex_preg = '0, ex_ppreg = '0;
    logic complete_val, complete_wen, commit_val, commit_wen;
    logic [SB-1:0] complete_seq_num, commit_seq_num;
    logic [4:0]    complete_waddr, commit_waddr;
    logic [31:0]   complete_wdata, commit_wdata, commit_pc;
    logic [PB-1:0] complete_preg, commit_ppreg;

    always #5 clk = ~clk;

    writeback_commit_unit_l3 #(.p_num_pipes(NP), .p_seq_num_bits(SB), .p_phys_addr_bits(PB)) dut (
        .clk(clk), .rst(rst), .ex_val(ex_val), .ex_rdy(ex_rdy), .ex_pc(ex_pc),
        .ex_seq_num(ex_seq_num), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_wen(ex_wen),
        .ex_preg(ex_preg), .ex_ppreg(ex_ppreg),
        .complete_val(complete_val), .complete_seq_num(complete_seq_num),
        .complete_waddr(complete_waddr), .complete_wdata(complete_wdata),
        .complete_wen(complete_wen), .complete_preg(complete_preg),
        .commit_val(commit_val), .commit_pc(commit_pc), .commit_seq_num(commit_seq_num),
        .commit_waddr(commit_waddr), .commit_wdata(commit_wdata), .commit_wen(commit_wen),
        .commit_ppreg(commit_ppreg));

    // Stimulus record; the expected completion/commit fields are the same
    // values passed through, so the record doubles as the expected output.
    typedef struct packed {
        int          grp;
        int          pipe;
        logic [31:0] pc;
        logic [2:0]  seq;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        wen;
        logic [5:0]  preg;
        logic [5:0]  ppreg;
    } vec_t;

    vec_t tbl[$];
    vec_t cpl_q[$];
    vec_t rob_m [DEPTH];
    bit   rob_v [DEPTH];
    int   head_m = 0;
    int   n_checks = 0, n_fail = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(int g, int p, logic [31:0] pc, logic [2:0] s, logic [4:0] wa,
                                logic [31:0] wd, logic we, logic [5:0] pr, logic [5:0] ppr);
        vec_t v;
        v.grp = g; v.pipe = p; v.pc = pc; v.seq = s; v.waddr = wa;
        v.wdata = wd; v.wen = we; v.preg = pr; v.ppreg = ppr;
        return v;
    endfunction

    task automatic model_accept(vec_t v);
        cpl_q.push_back(v);
        rob_m[v.seq] = v;
        rob_v[v.seq] = 1'b1;
    endtask

    task automatic model_clear();
        cpl_q.delete();
        for (int i = 0; i < DEPTH; i++) rob_v[i] = 1'b0;
        head_m = 0;
    endtask

    task automatic drive(int p, vec_t v);
        ex_val[p] = 1'b1; ex_pc[p] = v.pc; ex_seq_num[p] = v.seq; ex_waddr[p] = v.waddr;
        ex_wdata[p] = v.wdata; ex_wen[p] = v.wen; ex_preg[p] = v.preg; ex_ppreg[p] = v.ppreg;
    endtask

    task automatic send(vec_t v);
        logic [NP-1:0] exp_rdy;
        @(negedge clk);
        ex_val = '0;
        drive(v.pipe, v);
        #1;
        exp_rdy = '0;
        exp_rdy[v.pipe] = 1'b1;
        check("rdy_single", ex_rdy, exp_rdy);
        model_accept(v);
        @(posedge clk);
        #1 ex_val = '0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        ex_val = '0;
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(string name);
        int  k = 0;
        bit  busy = 1'b1;
        while (busy && k < 40) begin
            @(negedge clk);
            #1;
            k++;
            busy = (cpl_q.size() != 0);
            for (int i = 0; i < DEPTH; i++) if (rob_v[i]) busy = 1'b1;
        end
        n_checks++;
        if (busy) begin
            n_fail++;
            $display("FAIL %s: scoreboard still holds entries after %0d cycles", name, k);
        end
    endtask

    // Scoreboard monitor: completions in acceptance order, commits in seq
    // order, each exactly when the model says the DUT must produce it.
    always @(negedge clk) begin
        if (!rst) begin
            if (complete_val) begin
                if (cpl_q.size() == 0) check("complete_spurious", complete_val, 1'b0);
                else begin
                    vec_t c;
                    c = cpl_q.pop_front();
                    check("complete_seq",   complete_seq_num, c.seq);
                    check("complete_waddr", complete_waddr,   c.waddr);
                    check("complete_wdata", complete_wdata,   c.wdata);
                    check("complete_wen",   complete_wen,     c.wen);
                    check("complete_preg",  complete_preg,    c.preg);
                end
            end else if (cpl_q.size() != 0) begin
                check("complete_missing", complete_val, 1'b1);
                void'(cpl_q.pop_front());
            end
            if (commit_val) begin
                if (!rob_v[head_m]) check("commit_unexpected", commit_val, 1'b0);
                else begin
                    check("commit_pc",    commit_pc,      rob_m[head_m].pc);
                    check("commit_seq",   commit_seq_num, head_m);
                    check("commit_waddr", commit_waddr,   rob_m[head_m].waddr);
                    check("commit_wdata", commit_wdata,   rob_m[head_m].wdata);
                    check("commit_wen",   commit_wen,     rob_m[head_m].wen);
                    check("commit_ppreg", commit_ppreg,   rob_m[head_m].ppreg);
                    rob_v[head_m] = 1'b0;
                    head_m = (head_m + 1) % DEPTH;
                end
            end else if (rob_v[head_m]) begin
                check("commit_missing", commit_val, 1'b1);
            end
        end
    end

    initial begin
        vec_t a, b;
        // Table: group 0 single in-order, group 1 wen=0 via pipe 1,
        // group 2 wrap-around 0..7 then 0..3.
        tbl.push_back(mk(0, 0, 32'h1000, 3'd0, 5'd5, 32'hdeadbeef, 1'b1, 6'd3, 6'd1));
        tbl.push_back(mk(1, 1, 32'h2000, 3'd0, 5'd9, 32'h12345678, 1'b0, 6'd7, 6'd42));
        for (int i = 0; i < 12; i++)
            tbl.push_back(mk(2, 0, 32'h3000 + 32'(i * 4), 3'(i % 8), 5'(i + 1),
                             32'hA5A50000 + 32'(i), 1'(i % 2), 6'(i + 10), 6'(i + 30)));

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_complete_val", complete_val, 1'b0);
        check("rst_commit_val",   commit_val,   1'b0);
        check("rst_complete_wdata", complete_wdata, 32'h0);
        check("rst_complete_preg",  complete_preg,  6'h0);
        check("rst_commit_seq",   commit_seq_num, 3'h0);
        check("rst_commit_pc",    commit_pc,      32'h0);
        rst = 1'b0;
        @(negedge clk); #1;
        check("rdy_idle", ex_rdy, 2'b01);

        for (int g = 0; g < 3; g++) begin
            do_reset();
            for (int i = 0; i < tbl.size(); i++) if (tbl[i].grp == g) send(tbl[i]);
            drain($sformatf("drain_grp%0d", g));
        end

        // Reverse order: 2, 1 complete but cannot commit until 0 arrives.
        do_reset();
        send(mk(3, 0, 32'h4008, 3'd2, 5'd2, 32'h22, 1'b1, 6'd2, 6'd12));
        send(mk(3, 1, 32'h4004, 3'd1, 5'd1, 32'h11, 1'b1, 6'd1, 6'd11));
        @(negedge clk); #1;
        check("rev_no_commit", commit_val, 1'b0);
        send(mk(3, 0, 32'h4000, 3'd0, 5'd3, 32'h00, 1'b1, 6'd4, 6'd10));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("rev_consec_val", commit_val, 1'b1);
            check("rev_consec_seq", commit_seq_num, 3'(i));
        end
        drain("drain_rev");

        // Mid-stream reset with seq 1 in flight; seq 0 then commits alone.
        do_reset();
        send(mk(4, 0, 32'h5004, 3'd1, 5'd7, 32'hbad0_0001, 1'b1, 6'd5, 6'd15));
        @(negedge clk); #3;
        check("mrst_no_commit", commit_val, 1'b0);
        rst = 1'b1;
        model_clear();
        #1;
        check("mrst_commit_val",   commit_val,   1'b0);
        check("mrst_complete_val", complete_val, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        send(mk(4, 0, 32'h5000, 3'd0, 5'd8, 32'h600d_0000, 1'b1, 6'd6, 6'd16));
        repeat (4) @(negedge clk);
        drain("drain_mrst");

        // Two pipes valid together: pipe 0 first, pipe 1 next cycle.
        do_reset();
        a = mk(5, 0, 32'h6000, 3'd0, 5'd10, 32'haaaa, 1'b1, 6'd20, 6'd40);
        b = mk(5, 1, 32'h6004, 3'd1, 5'd11, 32'hbbbb, 1'b1, 6'd21, 6'd41);
        @(negedge clk);
        drive(0, a);
        drive(1, b);
        #1;
        check("two_rdy_first", ex_rdy, 2'b01);
        model_accept(a);
        @(posedge clk);
        #1 ex_val[0] = 1'b0;
        @(negedge clk); #1;
        check("two_rdy_second", ex_rdy, 2'b10);
        model_accept(b);
        @(posedge clk);
        #1 ex_val = '0;
        drain("drain_two");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
